regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have i_clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have i_reset_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have i_rd_valid  input  1  decode read request valid.
REQ-004 SHALL have o_rd_ready  output  1  read request accepted when high with i_rd_valid.
REQ-005 SHALL have i_rs1, i_rs2  input  5 each  source register indices.
REQ-006 SHALL have o_rsp_valid  output  1  operand response valid.
REQ-007 SHALL have i_rsp_ready  input  1  consumer takes response.
REQ-008 SHALL have o_rs1_data, o_rs2_data  output  32 each  operand values.
REQ-009 SHALL have i_wb_valid  input  1  writeback request valid.
REQ-010 SHALL have o_wb_ready  output  1  writeback accepted when high with i_wb_valid.
REQ-011 SHALL have i_wb_rd  input  5 and i_wb_data  input  32  writeback destination and value.
REQ-012 SHALL have o_rf_read_register_1, o_rf_read_register_2, o_rf_write_register  output  5 each  register file addresses.
REQ-013 SHALL have o_rf_write_data  output  32 and o_rf_we  output  1  register file write port.
REQ-014 SHALL have i_rf_read_data_1, i_rf_read_data_2  input  32 each  register file read data, registered by the file on each posedge where o_rf_we=0.

Function
REQ-015 SHALL buffer writebacks in a 2-entry FIFO; o_wb_ready = FIFO not full; accepted writes to index 0 SHALL be dropped (never pushed, still handshaken).
REQ-016 SHALL, each cycle the FIFO is non-empty, drive o_rf_we=1 with head entry on o_rf_write_register/o_rf_write_data and pop it at that posedge (one write per cycle, FIFO order).
REQ-017 SHALL, when o_rf_we=0, drive o_rf_read_register_1/2 from i_rs1/i_rs2 in the accept cycle, otherwise from the last accepted indices (held so register file re-reads are idempotent).
REQ-018 SHALL implement FSM IDLE, WAIT, HOLD; o_rd_ready=1 only in IDLE with FIFO empty.
REQ-019 SHALL transition IDLE->WAIT on read accept (cycle N, file samples addresses at end of N).
REQ-020 SHALL, in WAIT (cycle N+1), latch i_rf_read_data_1/2 into o_rs1_data/o_rs2_data, forcing 0 for index 0, and go to HOLD; latency accept->o_rsp_valid = 2 cycles.
REQ-021 SHALL assert o_rsp_valid only in HOLD, hold data stable until i_rsp_ready, then go to IDLE; HOLD->IDLE and new accept SHALL NOT overlap in one cycle.
REQ-022 SHALL allow writeback pushes and FIFO drains in every state; drains during WAIT/HOLD SHALL NOT alter latched operands.
REQ-023 SHALL treat a writeback accepted in the same cycle as a read accept as younger: read returns pre-write value; RAW ordering beyond this is upstream's responsibility.
REQ-024 SHALL push and pop the FIFO in the same cycle when non-full and non-empty, count unchanged.

Reset
REQ-025 SHALL, while i_reset_n=0 at posedge, go to IDLE, empty the FIFO, clear held indices to 0, and set o_rsp_valid=0, o_rs1_data=o_rs2_data=0.
REQ-026 SHALL, during reset, drive o_rf_we=0, o_rd_ready=0, o_wb_ready=0; reset mid-WAIT/HOLD SHALL discard the response and any buffered writes.

Verification
REQ-027 Write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> o_rsp_valid 2 cycles after accept, o_rs1_data=0xDEADBEEF, o_rs2_data=0.
REQ-028 Writeback x0=0x12345678 then read rs1=0 -> o_rf_we never asserted for index 0, o_rs1_data=0.
REQ-029 Three back-to-back writebacks x1..x3 with consumer idle -> o_wb_ready low after 2 entries only if no drain; all three written in order, o_rd_ready held low until FIFO empty.
REQ-030 Response held 5 cycles with i_rsp_ready=0 while writeback x7=0xA5A5A5A5 drains, prior read of x7 returned 0x11111111 -> o_rs1_data stays 0x11111111 all 5 cycles.
REQ-031 Same-cycle read accept of x9 and writeback x9=0x55 (x9 previously 0x44) -> o_rs1_data=0x44; subsequent read -> 0x55.
REQ-032 i_reset_n=0 asserted in HOLD with 1 FIFO entry -> next cycle o_rsp_valid=0, FIFO empty, no o_rf_we pulse, o_rd_ready=1 after release.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller between decode and a registered register file.
// Buffers writebacks in a 2-entry FIFO and serves two-operand reads via an IDLE/WAIT/HOLD FSM.
module regfile_access_ctrl (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rd_valid,
    output logic        o_rd_ready,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_wb_valid,
    output logic        o_wb_ready,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic [4:0]  o_rf_read_register_1,
    output logic [4:0]  o_rf_read_register_2,
    output logic [4:0]  o_rf_write_register,
    output logic [31:0] o_rf_write_data,
    output logic        o_rf_we,
    input  logic [31:0] i_rf_read_data_1,
    input  logic [31:0] i_rf_read_data_2
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  fifo_rd_q   [2];
    logic [31:0] fifo_data_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;
    logic [4:0]  rs1_q, rs2_q;
    logic [31:0] rs1_data_q, rs2_data_q;

    logic fifo_empty, fifo_full, rd_accept, push, pop;

    assign fifo_empty = (count_q == 2'd0);
    assign fifo_full  = (count_q == 2'd2);

    assign o_wb_ready = i_reset_n && !fifo_full;
    assign o_rf_we    = i_reset_n && !fifo_empty;
    assign pop        = o_rf_we;
    // Writes to x0 complete the handshake but never reach the file.
    assign push       = i_wb_valid && o_wb_ready && (i_wb_rd != 5'd0);
    assign rd_accept  = i_rd_valid && o_rd_ready;

    assign o_rf_write_register  = fifo_rd_q[rd_ptr_q];
    assign o_rf_write_data      = fifo_data_q[rd_ptr_q];
    // Holding the last indices keeps file re-reads on idle cycles harmless.
    assign o_rf_read_register_1 = rd_accept ? i_rs1 : rs1_q;
    assign o_rf_read_register_2 = rd_accept ? i_rs2 : rs2_q;

    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        o_rd_ready  = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_rd_ready = i_reset_n && fifo_empty;
                if (i_rd_valid && o_rd_ready) state_d = WAIT;
            end
            WAIT: state_d = HOLD;
            HOLD: begin
                o_rsp_valid = i_reset_n;
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rs1_data_q <= 32'd0;
            rs2_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (rd_accept) begin
                rs1_q <= i_rs1;
                rs2_q <= i_rs2;
            end
            if (state_q == WAIT) begin
                rs1_data_q <= (rs1_q == 5'd0) ? 32'd0 : i_rf_read_data_1;
                rs2_data_q <= (rs2_q == 5'd0) ? 32'd0 : i_rf_read_data_2;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= i_wb_rd;
            fifo_data_q[wr_ptr_q] <= i_wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench: register-file model, architectural reference state, directed and random traffic.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_rd_valid = 1'b0, i_rsp_ready = 1'b0, i_wb_valid = 1'b0;
    logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_rd_ready, o_rsp_valid, o_wb_ready, o_rf_we;
    logic [31:0] o_rs1_data, o_rs2_data, o_rf_write_data;
    logic [4:0]  o_rf_read_register_1, o_rf_read_register_2, o_rf_write_register;
    logic [31:0] rf_rd1 = '0, rf_rd2 = '0;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_rf_read_register_1(o_rf_read_register_1), .o_rf_read_register_2(o_rf_read_register_2),
        .o_rf_write_register(o_rf_write_register), .o_rf_write_data(o_rf_write_data),
        .o_rf_we(o_rf_we),
        .i_rf_read_data_1(rf_rd1), .i_rf_read_data_2(rf_rd2)
    );

    // Register file: writes when we=1, otherwise registers both read ports.
    logic [31:0] rf_mem [32];
    initial foreach (rf_mem[i]) rf_mem[i] = '0;
    always @(posedge clk) begin
        if (o_rf_we) rf_mem[o_rf_write_register] <= o_rf_write_data;
        else begin
            rf_rd1 <= rf_mem[o_rf_read_register_1];
            rf_rd2 <= rf_mem[o_rf_read_register_2];
        end
    end

    int checks = 0, failures = 0, cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: committed architectural values plus accepted-but-unwritten writebacks.
    typedef struct { logic [31:0] d1, d2; int acc; } rsp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
    logic [31:0] committed [32];
    initial foreach (committed[i]) committed[i] = '0;
    rsp_t exp_rsp [$];
    wr_t  pend [$];
    bit   rsp_seen = 0;

    function automatic logic [31:0] model_val(input logic [4:0] r);
        logic [31:0] v;
        if (r == 5'd0) return 32'd0;
        v = committed[r];
        foreach (pend[i]) if (pend[i].rd == r) v = pend[i].data;
        return v;
    endfunction

    // Issue side: on each accepted handshake push the expected outcome.
    always @(negedge clk) begin
        cycle++;
        if (!i_reset_n) begin
            exp_rsp.delete();
            pend.delete();
        end else begin
            if (i_rd_valid && o_rd_ready)
                exp_rsp.push_back('{model_val(i_rs1), model_val(i_rs2), cycle});
            if (i_wb_valid && o_wb_ready && i_wb_rd != 5'd0)
                pend.push_back('{i_wb_rd, i_wb_data});
        end
    end

    // Monitor side: pop and compare whatever the DUT presents.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        #1;
        if (!i_reset_n) begin
            check("reset_rf_we", o_rf_we, 0);
            check("reset_rd_ready", o_rd_ready, 0);
            check("reset_wb_ready", o_wb_ready, 0);
            rsp_seen = 0;
        end else begin
            if (o_rf_we) begin
                check("rd_ready_low_while_fifo_busy", o_rd_ready, 0);
                if (pend.size() == 0) fail("unexpected_rf_write");
                else begin
                    w = pend.pop_front();
                    check("rf_write_addr", o_rf_write_register, w.rd);
                    check("rf_write_data", o_rf_write_data, w.data);
                    committed[w.rd] = w.data;
                end
            end
            if (o_rsp_valid) begin
                if (exp_rsp.size() == 0) fail("unexpected_rsp_valid");
                else begin
                    e = exp_rsp[0];
                    if (!rsp_seen) check("rsp_latency", cycle - e.acc, 2);
                    rsp_seen = 1;
                    check("rs1_data", o_rs1_data, e.d1);
                    check("rs2_data", o_rs2_data, e.d2);
                    if (i_rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        rsp_seen = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_ready();
        for (int n = 0; n < 50 && !o_rd_ready; n++) tick();
        if (!o_rd_ready) fail("timeout_rd_ready");
    endtask

    task automatic wait_rsp_valid();
        for (int n = 0; n < 50 && !o_rsp_valid; n++) tick();
        if (!o_rsp_valid) fail("timeout_rsp_valid");
    endtask

    task automatic wb_op(input logic [4:0] rd, input logic [31:0] data);
        for (int n = 0; n < 50 && !o_wb_ready; n++) tick();
        if (!o_wb_ready) fail("timeout_wb_ready");
        i_wb_valid = 1; i_wb_rd = rd; i_wb_data = data;
        tick();
        i_wb_valid = 0;
    endtask

    task automatic read_op(input logic [4:0] rs1, input logic [4:0] rs2);
        wait_rd_ready();
        i_rd_valid = 1; i_rs1 = rs1; i_rs2 = rs2;
        tick();
        i_rd_valid = 0;
    endtask

    task automatic take_rsp(input int hold);
        wait_rsp_valid();
        repeat (hold) tick();
        i_rsp_ready = 1;
        tick();
        i_rsp_ready = 0;
    endtask

    initial begin
        #1;
        repeat (3) tick();
        check("reset_rsp_valid", o_rsp_valid, 0);
        check("reset_rs1_data", o_rs1_data, 0);
        check("reset_rs2_data", o_rs2_data, 0);
        i_reset_n = 1;
        #1;
        check("post_reset_rd_ready", o_rd_ready, 1);
        check("post_reset_wb_ready", o_wb_ready, 1);
        tick();

        // x5 write then read with rs2=x0
        wb_op(5, 32'hDEADBEEF);
        read_op(5, 0);
        take_rsp(0);

        // write to x0 is dropped
        wb_op(0, 32'h12345678);
        #1 check("x0_write_no_we", o_rf_we, 0);
        read_op(0, 5);
        take_rsp(0);

        // three back-to-back writebacks
        for (int i = 1; i <= 3; i++) wb_op(i[4:0], 32'h1000_0000 + i);
        read_op(3, 1);
        take_rsp(1);

        // operands stay stable across a drain while held
        wb_op(7, 32'h11111111);
        read_op(7, 2);
        wait_rsp_valid();
        wb_op(7, 32'hA5A5A5A5);
        repeat (4) tick();
        take_rsp(0);
        read_op(7, 0);
        take_rsp(0);

        // same-cycle read accept and writeback to the same register
        wb_op(9, 32'h44);
        wait_rd_ready();
        i_rd_valid = 1; i_rs1 = 9; i_rs2 = 9;
        i_wb_valid = 1; i_wb_rd = 9; i_wb_data = 32'h55;
        tick();
        i_rd_valid = 0; i_wb_valid = 0;
        take_rsp(0);
        read_op(9, 0);
        take_rsp(0);

        // reset while in HOLD with one buffered write
        read_op(1, 2);
        wait_rsp_valid();
        wb_op(3, 32'h77777777);
        i_reset_n = 0;
        tick();
        check("hold_reset_rsp_valid", o_rsp_valid, 0);
        check("hold_reset_rs1_data", o_rs1_data, 0);
        i_reset_n = 1;
        #1;
        check("hold_reset_rd_ready", o_rd_ready, 1);
        check("hold_reset_fifo_empty", o_rf_we, 0);
        read_op(3, 9);
        take_rsp(0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            i_rd_valid  = $urandom_range(0, 1);
            i_rs1       = 5'($urandom_range(0, 7));
            i_rs2       = 5'($urandom_range(0, 7));
            i_wb_valid  = ($urandom_range(0, 2) == 0);
            i_wb_rd     = 5'($urandom_range(0, 7));
            i_wb_data   = $urandom;
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_rd_valid = 0; i_wb_valid = 0; i_rsp_ready = 1;
        repeat (20) tick();
        check("rsp_queue_drained", exp_rsp.size(), 0);
        check("write_queue_drained", pend.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not terminate");
    end

endmodule
